// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from variable-latency imem, holds instr for decode.
// Latency: 2 + L (memory wait) + S (decode stall) cycles per instruction.
// Backpressure: instr is held in HOLD until instr_ready; no new request is issued meanwhile.
module fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_valid,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] retired,
    output logic             fault,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] retired_q, retired_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] next_pc;

    // Carry out of the add is discarded, so the PC wraps naturally.
    assign next_pc = PCsrc ? (pc_q + ImmOp) : (pc_q + WIDTH'(4));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        fault_d     = fault_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retired_d = retired_q + WIDTH'(1);
                    // A misaligned target leaves pc on the offending branch for debug.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else if (halt) begin
                        pc_d    = next_pc;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign fault     = fault_q;

endmodule
